// File: rtl/btn_evt_pkg.sv
// Shared event kinds, tracker states and the pending-slot bundle
// used by the button event arbiter and its per-button trackers.
package btn_evt_pkg;

    localparam int KIND_W = 2;

    localparam logic [KIND_W-1:0] EVT_PRESS   = 2'd0;
    localparam logic [KIND_W-1:0] EVT_RELEASE = 2'd1;
    localparam logic [KIND_W-1:0] EVT_LONG    = 2'd2;
    localparam logic [KIND_W-1:0] EVT_REPEAT  = 2'd3;

    typedef enum logic [1:0] {
        ST_UP    = 2'd0,
        ST_DOWN  = 2'd1,
        ST_LONGH = 2'd2
    } trk_state_t;

    typedef struct packed {
        logic              valid;
        logic [KIND_W-1:0] kind;
    } pend_t;

endpackage

// File: rtl/btn_event_arbiter_tracker.sv
// Per-button tracker: edge detect, hold/repeat FSM with a saturating
// counter, and a one-deep pending event slot.
module btn_tracker
    import btn_evt_pkg::*;
#(
    parameter int CNT_W         = 26,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  lvl,
    input  logic  grant,
    output pend_t pend,
    output logic  ovf_set
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    trk_state_t        state;
    trk_state_t        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              prev_lvl;
    logic              rise;
    logic              fall;
    logic              evt;
    logic [KIND_W-1:0] evt_kind;

    assign rise    = lvl & ~prev_lvl;
    assign fall    = ~lvl & prev_lvl;
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
    // A grant in the same cycle frees the slot, so no overflow then.
    assign ovf_set = evt & pend.valid & ~grant;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        evt       = 1'b0;
        evt_kind  = EVT_PRESS;
        if (fall) begin
            state_nxt = ST_UP;
            cnt_nxt   = '0;
            evt       = 1'b1;
            evt_kind  = EVT_RELEASE;
        end else begin
            unique case (state)
                ST_UP: begin
                    if (rise) begin
                        state_nxt = ST_DOWN;
                        cnt_nxt   = '0;
                        evt       = 1'b1;
                        evt_kind  = EVT_PRESS;
                    end
                end
                ST_DOWN: begin
                    if (cnt == HOLD_LAST) begin
                        state_nxt = ST_LONGH;
                        cnt_nxt   = '0;
                        evt       = 1'b1;
                        evt_kind  = EVT_LONG;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                ST_LONGH: begin
                    if (REPEAT_CYCLES != 0) begin
                        if (cnt == REP_LAST) begin
                            cnt_nxt  = '0;
                            evt      = 1'b1;
                            evt_kind = EVT_REPEAT;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                end
                default: state_nxt = ST_UP;
            endcase
        end
    end

    // prev_lvl tracks the input through reset so a held button is not a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_UP;
            cnt      <= '0;
            prev_lvl <= lvl;
            pend     <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            prev_lvl <= lvl;
            if (evt) begin
                pend <= '{valid: 1'b1, kind: evt_kind};
            end else if (grant) begin
                pend.valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/btn_event_arbiter.sv
// Button event arbiter: per-button trackers feed a round-robin arbiter
// that serializes their events onto one registered valid/ready port.
module btn_event_arbiter
    import btn_evt_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int ID_W          = 2,
    parameter int CNT_W         = 26,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BTN-1:0]  btn_lvl,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [ID_W-1:0]   evt_id,
    output logic [KIND_W-1:0] evt_kind,
    output logic              ovf,
    input  logic              ovf_clr
);

    pend_t            pend [N_BTN];
    logic [N_BTN-1:0] grant;
    logic [N_BTN-1:0] ovf_set;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  ptr_nxt;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_any;
    logic             issue;

    for (genvar g = 0; g < N_BTN; g++) begin : gen_trk
        btn_tracker #(
            .CNT_W        (CNT_W),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_trk (
            .clk    (clk),
            .rst    (rst),
            .lvl    (btn_lvl[g]),
            .grant  (grant[g]),
            .pend   (pend[g]),
            .ovf_set(ovf_set[g])
        );
    end

    // Output slot is free when empty or being drained this cycle.
    assign issue = ~evt_valid | evt_ready;

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int k = 0; k < N_BTN; k++) begin
            if (!gnt_any && pend[(int'(ptr) + k) % N_BTN].valid) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'((int'(ptr) + k) % N_BTN);
            end
        end
    end

    assign grant   = (issue && gnt_any) ? (N_BTN'(1) << gnt_id) : '0;
    assign ptr_nxt = (gnt_id == ID_W'(N_BTN - 1)) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_kind  <= EVT_PRESS;
            ptr       <= '0;
            ovf       <= 1'b0;
        end else begin
            if (issue) begin
                evt_valid <= gnt_any;
                if (gnt_any) begin
                    evt_id   <= gnt_id;
                    evt_kind <= pend[gnt_id].kind;
                    ptr      <= ptr_nxt;
                end
            end
            if (|ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Scoreboard bench for btn_event_arbiter: a hold-time event model feeds an
// expected queue, a monitor pops and compares on every handshake.
module tb_btn_event_arbiter;
    import btn_evt_pkg::*;

    localparam int N    = 4;
    localparam int HOLD = 8;
    localparam int REP  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_lvl = '0;
    logic         evt_ready = 1'b1;
    logic         ovf_clr = 1'b0;
    logic         evt_valid;
    logic [1:0]   evt_id;
    logic [1:0]   evt_kind;
    logic         ovf;

    btn_event_arbiter #(
        .N_BTN        (N),
        .ID_W         (2),
        .CNT_W        (8),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_lvl  (btn_lvl),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_id   (evt_id),
        .evt_kind (evt_kind),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int kind;
        int cyc;
    } ev_t;

    ev_t expq[$];
    ev_t hs_log[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    bit  chk_en = 1'b1;
    bit  rst_q = 1'b1;
    bit  prev_m[N];
    bit  held_m[N];
    int  press_m[N];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic void push_ev(input int id, input int kind);
        if (chk_en) expq.push_back('{id: id, kind: kind, cyc: cyc});
    endfunction

    // Reference: events follow from level history and hold duration.
    always @(posedge clk) begin
        int d;
        cyc++;
        rst_q = rst;
        if (rst) begin
            expq.delete();
            for (int i = 0; i < N; i++) begin
                prev_m[i] = btn_lvl[i];
                held_m[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (btn_lvl[i] && !prev_m[i]) begin
                    held_m[i]  = 1'b1;
                    press_m[i] = cyc;
                    push_ev(i, EVT_PRESS);
                end else if (!btn_lvl[i] && prev_m[i]) begin
                    held_m[i] = 1'b0;
                    push_ev(i, EVT_RELEASE);
                end else if (held_m[i]) begin
                    d = cyc - press_m[i];
                    if (d == HOLD) push_ev(i, EVT_LONG);
                    else if (d > HOLD && (d - HOLD) % REP == 0)
                        push_ev(i, EVT_REPEAT);
                end
                prev_m[i] = btn_lvl[i];
            end
        end
    end

    bit       stall_q = 1'b0;
    bit [1:0] hold_id;
    bit [1:0] hold_kind;

    always @(negedge clk) begin
        int f;
        int lat;
        if (cyc > 0) begin
            if (rst_q) chk("rst_valid", evt_valid, 0);
            if (!rst && !rst_q && stall_q) begin
                chk("hold_valid", evt_valid, 1);
                chk("hold_id", evt_id, hold_id);
                chk("hold_kind", evt_kind, hold_kind);
            end
            if (!rst && evt_valid && evt_ready) begin
                hs_log.push_back('{id: evt_id, kind: evt_kind, cyc: cyc});
                if (chk_en) begin
                    f = -1;
                    foreach (expq[k]) if (f < 0 && expq[k].id == evt_id) f = k;
                    if (f < 0) begin
                        checks++;
                        failures++;
                        $display("FAIL mon_unexpected id=%0d kind=%0d cyc=%0d required=none",
                                 evt_id, evt_kind, cyc);
                    end else begin
                        chk("mon_kind", evt_kind, expq[f].kind);
                        lat = cyc - expq[f].cyc;
                        checks++;
                        if (lat < 1 || lat > 4) begin
                            failures++;
                            $display("FAIL mon_latency id=%0d actual=%0d required=1..4",
                                     evt_id, lat);
                        end
                        expq.delete(f);
                    end
                end
            end
            stall_q   = !rst && evt_valid && !evt_ready;
            hold_id   = evt_id;
            hold_kind = evt_kind;
        end
    end

    int dur_tab[9] = '{5, 6, 7, 8, 12, 16, 20, 24, 28};
    int rem[N];

    initial begin
        rst = 1'b1;
        step(2);
        chk("reset_valid", evt_valid, 0);
        chk("reset_id", evt_id, 0);
        chk("reset_kind", evt_kind, 0);
        chk("reset_ovf", ovf, 0);
        rst = 1'b0;
        step(2);

        // short press on btn2
        btn_lvl[2] = 1'b1;
        step(3);
        btn_lvl[2] = 1'b0;
        step(6);
        chk("t1_ovf", ovf, 0);

        // long hold on btn1
        hs_log.delete();
        btn_lvl[1] = 1'b1;
        step(21);
        btn_lvl[1] = 1'b0;
        step(8);
        chk("t2_count", hs_log.size(), 6);
        if (hs_log.size() == 6) begin
            chk("t2_long_kind", hs_log[1].kind, EVT_LONG);
            chk("t2_long_gap", hs_log[1].cyc - hs_log[0].cyc, HOLD);
            for (int k = 2; k < 5; k++) begin
                chk("t2_rep_kind", hs_log[k].kind, EVT_REPEAT);
                chk("t2_rep_gap", hs_log[k].cyc - hs_log[k-1].cyc, REP);
            end
            chk("t2_last_kind", hs_log[5].kind, EVT_RELEASE);
        end

        // park the RR pointer at 1 via btn0, then btn0+btn3 together
        btn_lvl[0] = 1'b1;
        step(2);
        btn_lvl[0] = 1'b0;
        step(6);
        hs_log.delete();
        btn_lvl[0] = 1'b1;
        btn_lvl[3] = 1'b1;
        step(6);
        chk("t3_count", hs_log.size(), 2);
        if (hs_log.size() == 2) begin
            chk("t3_first_id", hs_log[0].id, 3);
            chk("t3_second_id", hs_log[1].id, 0);
            chk("t3_gap", hs_log[1].cyc - hs_log[0].cyc, 1);
        end
        btn_lvl[0] = 1'b0;
        btn_lvl[3] = 1'b0;
        step(6);

        // backpressure, overwrite and sticky ovf
        chk_en = 1'b0;
        evt_ready = 1'b0;
        btn_lvl[0] = 1'b1;
        step(3);
        chk("t4_valid", evt_valid, 1);
        chk("t4_id", evt_id, 0);
        chk("t4_kind", evt_kind, EVT_PRESS);
        btn_lvl[0] = 1'b0;
        step(3);
        chk("t4_ovf_idle", ovf, 0);
        chk("t4_kind_held", evt_kind, EVT_PRESS);
        btn_lvl[0] = 1'b1;
        step(3);
        chk("t4_ovf_set", ovf, 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", ovf, 0);
        hs_log.delete();
        evt_ready = 1'b1;
        step(4);
        chk("t4_drain_count", hs_log.size(), 2);
        if (hs_log.size() == 2) begin
            chk("t4_drain_id", hs_log[1].id, 0);
            chk("t4_drain_kind", hs_log[1].kind, EVT_PRESS);
        end
        rst = 1'b1;
        chk_en = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);

        // reset with btn1 held
        btn_lvl[1] = 1'b1;
        step(12);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        hs_log.delete();
        step(12);
        btn_lvl[1] = 1'b0;
        step(6);
        chk("t5_count", hs_log.size(), 1);
        if (hs_log.size() == 1) begin
            chk("t5_id", hs_log[0].id, 1);
            chk("t5_kind", hs_log[0].kind, EVT_RELEASE);
        end
        btn_lvl[0] = 1'b0;
        step(6);

        // random hold patterns on all buttons
        for (int i = 0; i < N; i++) rem[i] = $urandom_range(1, 10);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) begin
                    btn_lvl[i] = ~btn_lvl[i];
                    rem[i] = btn_lvl[i] ? dur_tab[$urandom_range(0, 8)]
                                        : $urandom_range(5, 30);
                end
                rem[i]--;
            end
            step(1);
        end
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < N; i++) begin
                if (btn_lvl[i]) begin
                    if (rem[i] == 0) btn_lvl[i] = 1'b0;
                    else rem[i]--;
                end
            end
            step(1);
        end
        step(10);
        chk("sb_left", expq.size(), 0);
        chk("end_ovf", ovf, 0);
        chk("end_valid", evt_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
